// File: rtl/admo_lsu.sv
// admo_lsu: load/store unit for the admo RV32I core.
// Takes one memory op from execute, runs a single req/gnt/rvalid bus
// transaction, and returns lane-steered, extended load data.
module admo_lsu (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic                    valid_q, valid_d;
  logic                    mis_q, mis_d;
  logic                    we_q, we_d;
  logic                    uns_q, uns_d;
  logic [1:0]              size_q, size_d;
  logic [1:0]              off_q, off_d;
  logic [3:0]              be_q, be_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    misaligned;
  logic                    accept;
  logic [3:0]              be_calc;
  logic [DATA_WIDTH-1:0]   wdata_calc;
  logic [DATA_WIDTH-1:0]   ld_shift;
  logic [DATA_WIDTH-1:0]   ld_ext;

  // Alignment check, byte enables and store lane replication for the incoming op
  always_comb begin
    misaligned = ((size_i == 2'b01) & addr_i[0]) | (size_i[1] & (|addr_i[1:0]));
    accept     = (state_q == S_IDLE) & req_i & ~misaligned;
    case (size_i)
      2'b00: begin
        be_calc    = 4'b0001 << addr_i[1:0];
        wdata_calc = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << addr_i[1:0];
        wdata_calc = {2{wdata_i[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_i;
      end
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then extend
  always_comb begin
    ld_shift = data_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'b0, ld_shift[7:0]}
                              : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_ext = uns_q ? {16'b0, ld_shift[15:0]}
                              : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // Next-state logic for the FSM and all registered outputs
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    valid_d = 1'b0;
    mis_d   = 1'b0;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    off_d   = off_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (misaligned) begin
            mis_d = 1'b1;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            we_d    = we_i;
            uns_d   = unsigned_i;
            size_d  = size_i;
            off_d   = addr_i[1:0];
            be_d    = be_calc;
            addr_d  = {addr_i[31:2], 2'b00};
            wdata_d = wdata_calc;
          end
        end
      end
      S_REQ: begin
        // Bus outputs are held until the grant is seen
        if (data_gnt_i) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (data_rvalid_i) begin
          state_d = S_IDLE;
          valid_d = 1'b1;
          if (!we_q) rdata_d = ld_ext;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset drops the bus request immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      off_q   <= off_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy_o       = accept | (state_q == S_REQ) | (state_q == S_WAIT);
  assign valid_o      = valid_q;
  assign rdata_o      = rdata_q;
  assign misaligned_o = mis_q;
  assign data_req_o   = req_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_admo_lsu.sv
// Self-checking bench for admo_lsu: directed scenarios plus randomized
// transactions checked against a byte-level reference model.
module tb_admo_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, valid_o, misaligned_o;
  logic [31:0] rdata_o;
  logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd = '0;

  always #5 clk_i = ~clk_i;

  admo_lsu dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o),
    .valid_o(valid_o), .rdata_o(rdata_o), .misaligned_o(misaligned_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] s, input logic [31:0] a);
    int n = nbytes(s);
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] w);
    logic [31:0] r;
    int n = nbytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] s, input logic u,
                                         input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(s);
    logic [63:0] v    = 64'(rd) >> (8 * a[1:0]);
    logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
    v = v & mask;
    if (!u && n < 4 && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives one aligned transaction with given wait states and records what the DUT did.
  // Starts and ends at posedge+1 with the DUT idle.
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] w,
                         input int gw, input int rw, input logic [31:0] rd,
                         output logic busy0, output logic [31:0] b_addr,
                         output logic [31:0] b_wdata, output logic [3:0] b_be,
                         output logic b_we, output logic bus_ok, output logic busy_mid,
                         output int lat, output logic v_end, output logic [31:0] rdat,
                         output logic busy_v, output int stray);
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = u; addr_i = a; wdata_i = w;
    #1 busy0 = busy_o;
    tick();
    req_i = 1'b0; we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
    lat = 1; bus_ok = (data_req_o === 1'b1); busy_mid = 1'b1; stray = 0;
    b_addr = data_addr_o; b_wdata = data_wdata_o; b_be = data_be_o; b_we = data_we_o;
    for (int g = 0; g <= gw; g++) begin
      data_gnt_i = (g == gw);
      bus_ok = bus_ok & (data_req_o === 1'b1) & (data_addr_o === b_addr) &
               (data_wdata_o === b_wdata) & (data_be_o === b_be) & (data_we_o === b_we);
      busy_mid = busy_mid & (busy_o === 1'b1);
      stray += (valid_o === 1'b1) ? 1 : 0;
      tick();
      lat++;
    end
    data_gnt_i = 1'b0;
    for (int r = 0; r <= rw; r++) begin
      data_rvalid_i = (r == rw);
      data_rdata_i  = (r == rw) ? rd : $urandom;
      bus_ok = bus_ok & (data_req_o === 1'b0);
      busy_mid = busy_mid & (busy_o === 1'b1);
      stray += (valid_o === 1'b1) ? 1 : 0;
      tick();
      lat++;
    end
    data_rvalid_i = 1'b0; data_rdata_i = $urandom;
    v_end = valid_o; rdat = rdata_o; busy_v = busy_o;
    tick();
    stray += (valid_o === 1'b1) ? 1 : 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0; req_i = 0; we_i = 0; size_i = 0; unsigned_i = 0; addr_i = 0; wdata_i = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
    tick(); tick();
    checks++;
    if ({busy_o, valid_o, misaligned_o, data_req_o, data_we_o, data_be_o} !== 9'b0 ||
        rdata_o !== 32'h0 || data_addr_o !== 32'h0 || data_wdata_o !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got req=%b busy=%b be=%h addr=%h rdata=%h exp all 0",
                         data_req_o, busy_o, data_be_o, data_addr_o, rdata_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_word_load();
    logic b0, we, ok, bm, ve, bv; logic [31:0] ad, wd, rd; logic [3:0] be; int lat, st;
    run_txn(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 0, 0, 32'hDEADBEEF,
            b0, ad, wd, be, we, ok, bm, lat, ve, rd, bv, st);
    checks++; if (ad !== 32'h1000) begin errors++; $display("FAIL wl_addr got %h exp %h", ad, 32'h1000); end
    checks++; if (be !== 4'b1111) begin errors++; $display("FAIL wl_be got %b exp 1111", be); end
    checks++; if (lat !== 3 || ve !== 1'b1) begin errors++; $display("FAIL wl_latency got lat=%0d valid=%b exp 3/1", lat, ve); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_rdata got %h exp DEADBEEF", rd); end
    checks++; if (b0 !== 1'b1 || bm !== 1'b1 || bv !== 1'b0 || st !== 0 || !ok) begin
      errors++; $display("FAIL wl_handshake got busy0=%b busy=%b busy_v=%b stray=%0d bus_ok=%b", b0, bm, bv, st, ok); end
    last_rd = 32'hDEADBEEF;
  endtask

  task automatic test_byte_load();
    logic b0, we, ok, bm, ve, bv; logic [31:0] ad, wd, rd; logic [3:0] be; int lat, st;
    run_txn(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 0, 0, 32'h80FFFFFF,
            b0, ad, wd, be, we, ok, bm, lat, ve, rd, bv, st);
    checks++; if (be !== 4'b1000) begin errors++; $display("FAIL bl_be got %b exp 1000", be); end
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL bl_signed got %h exp FFFFFF80", rd); end
    run_txn(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 0, 0, 32'h80FFFFFF,
            b0, ad, wd, be, we, ok, bm, lat, ve, rd, bv, st);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL bl_unsigned got %h exp 00000080", rd); end
    checks++; if (ad !== 32'h1000) begin errors++; $display("FAIL bl_addr got %h exp 00001000", ad); end
    last_rd = 32'h00000080;
  endtask

  task automatic test_half_store();
    logic b0, we, ok, bm, ve, bv; logic [31:0] ad, wd, rd; logic [3:0] be; int lat, st;
    run_txn(1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234ABCD, 3, 0, 32'h55555555,
            b0, ad, wd, be, we, ok, bm, lat, ve, rd, bv, st);
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL hs_we got %b exp 1", we); end
    checks++; if (be !== 4'b1100) begin errors++; $display("FAIL hs_be got %b exp 1100", be); end
    checks++; if (wd !== 32'hABCDABCD) begin errors++; $display("FAIL hs_wdata got %h exp ABCDABCD", wd); end
    checks++; if (!ok) begin errors++; $display("FAIL hs_stable got unstable bus exp stable"); end
    checks++; if (b0 !== 1'b1 || bm !== 1'b1 || bv !== 1'b0) begin
      errors++; $display("FAIL hs_busy got %b%b%b exp 110", b0, bm, bv); end
    checks++; if (lat !== 6 || ve !== 1'b1) begin errors++; $display("FAIL hs_latency got %0d/%b exp 6/1", lat, ve); end
    checks++; if (rd !== last_rd) begin errors++; $display("FAIL hs_rdata_hold got %h exp %h", rd, last_rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [2] = '{32'h3001, 32'h3003};
    logic [1:0]  sizes [2] = '{2'b10, 2'b01};
    for (int k = 0; k < 2; k++) begin
      int pulses = 0; int reqs = 0; int vals = 0; logic b;
      req_i = 1'b1; we_i = 1'b0; size_i = sizes[k]; addr_i = addrs[k]; unsigned_i = 1'b0;
      #1 b = busy_o;
      tick();
      req_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
        pulses += misaligned_o ? 1 : 0;
        reqs   += data_req_o ? 1 : 0;
        vals   += valid_o ? 1 : 0;
        if (c == 0) begin
          checks++; if (misaligned_o !== 1'b1) begin errors++; $display("FAIL mis_pulse_%0d got %b exp 1", k, misaligned_o); end
        end
        tick();
      end
      checks++; if (pulses !== 1 || reqs !== 0 || vals !== 0 || b !== 1'b0) begin
        errors++; $display("FAIL mis_effects_%0d got pulses=%0d reqs=%0d valids=%0d busy=%b exp 1/0/0/0", k, pulses, reqs, vals, b); end
    end
  endtask

  task automatic test_reset_mid();
    logic b0, we, ok, bm, ve, bv; logic [31:0] ad, wd, rd; logic [3:0] be; int lat, st;
    // reset while in REQ: request must drop without a clock edge
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; addr_i = 32'h5000; unsigned_i = 1'b0;
    tick(); req_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL rst_req_drop got %b exp 0", data_req_o); end
    tick(); rst_ni = 1'b1; tick();
    // reset while in WAIT, then a stale rvalid
    req_i = 1'b1; addr_i = 32'h5004;
    tick(); req_i = 1'b0; data_gnt_i = 1'b1;
    tick(); data_gnt_i = 1'b0;
    #2 rst_ni = 1'b0;
    tick(); rst_ni = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
    tick(); data_rvalid_i = 1'b0;
    tick();
    checks++;
    if ({busy_o, valid_o, misaligned_o, data_req_o, data_we_o, data_be_o} !== 9'b0 ||
        rdata_o !== 32'h0 || data_addr_o !== 32'h0 || data_wdata_o !== 32'h0) begin
      errors++; $display("FAIL rst_wait_outputs got valid=%b req=%b rdata=%h addr=%h exp all 0",
                         valid_o, data_req_o, rdata_o, data_addr_o);
    end
    last_rd = 32'h0;
    run_txn(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 0, 0, 32'h13579BDF,
            b0, ad, wd, be, we, ok, bm, lat, ve, rd, bv, st);
    checks++; if (ve !== 1'b1 || rd !== 32'h13579BDF || ad !== 32'h4000 || lat !== 3) begin
      errors++; $display("FAIL rst_recover got valid=%b rdata=%h addr=%h lat=%0d exp 1/13579BDF/4000/3", ve, rd, ad, lat); end
    last_rd = 32'h13579BDF;
  endtask

  task automatic test_back_to_back();
    logic b0, we, ok, bm, ve, bv; logic [31:0] ad, wd, rd; logic [3:0] be; int lat, st;
    int nvalid = 0; int nstray = 0; logic busy_good = 1'b1;
    run_txn(1'b0, 2'b01, 1'b1, 32'h6002, 32'h0, 0, 2, 32'hBEEF1234,
            b0, ad, wd, be, we, ok, bm, lat, ve, rd, bv, st);
    nvalid += ve; nstray += st; busy_good = busy_good & b0 & bm & ~bv;
    checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL b2b_load got %h exp 0000BEEF", rd); end
    run_txn(1'b1, 2'b00, 1'b0, 32'h6001, 32'h000000A5, 0, 2, 32'h0,
            b0, ad, wd, be, we, ok, bm, lat, ve, rd, bv, st);
    nvalid += ve; nstray += st; busy_good = busy_good & b0 & bm & ~bv;
    checks++; if (nvalid !== 2 || nstray !== 0) begin errors++; $display("FAIL b2b_valids got %0d pulses %0d stray exp 2/0", nvalid, nstray); end
    checks++; if (busy_good !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy_good); end
    checks++; if (wd !== 32'hA5A5A5A5 || be !== 4'b0010 || rd !== 32'h0000BEEF) begin
      errors++; $display("FAIL b2b_store got wdata=%h be=%b rdata=%h exp A5A5A5A5/0010/0000BEEF", wd, be, rd); end
    last_rd = 32'h0000BEEF;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic b0, bwe, ok, bm, ve, bv; logic [31:0] ad, wd, rd; logic [3:0] be; int lat, st;
      logic we = 1'($urandom);
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic u = 1'($urandom);
      logic [31:0] a = $urandom, w = $urandom, bus = $urandom;
      int gw = $urandom_range(0, 3), rw = $urandom_range(0, 3);
      logic [31:0] exp_rd;
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz[1]) a[1:0] = 2'b00;
      run_txn(we, sz, u, a, w, gw, rw, bus, b0, ad, wd, be, bwe, ok, bm, lat, ve, rd, bv, st);
      exp_rd = we ? last_rd : m_load(sz, u, a, bus);
      checks++; if (ad !== {a[31:2], 2'b00} || be !== m_be(sz, a) || bwe !== we) begin
        errors++; $display("FAIL rnd%0d_bus got addr=%h be=%b we=%b exp %h/%b/%b", n, ad, be, bwe, {a[31:2], 2'b00}, m_be(sz, a), we); end
      checks++; if (wd !== m_wdata(sz, w)) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h", n, wd, m_wdata(sz, w)); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", n, rd, exp_rd); end
      checks++; if (lat !== 3 + gw + rw || ve !== 1'b1 || st !== 0 || !ok || !b0 || !bm || bv) begin
        errors++; $display("FAIL rnd%0d_timing got lat=%0d valid=%b stray=%0d ok=%b busy=%b%b%b exp lat=%0d", n, lat, ve, st, ok, b0, bm, bv, 3 + gw + rw); end
      last_rd = exp_rd;
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/admo_lsu.md
# admo_lsu

Load/store unit for the admo RV32I core, sitting directly downstream of the ALU. It takes the ALU's effective-address result and load/store attributes from the execute stage, runs one transaction on a request/grant/response data bus, and returns load data to writeback. It handles byte-lane steering, byte enables and sign/zero extension, and flags misaligned accesses. It stalls the pipeline while a transaction is outstanding.

## Interface
Parameters: none. Data and address widths are `DATA_WIDTH` (32).

- clk_i  in  1  core clock
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- req_i  in  1  execute stage requests a memory operation this cycle
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 halfword, 10/11 word
- unsigned_i  in  1  loads: 1 = zero-extend, 0 = sign-extend
- addr_i  in  32  effective address, from the ALU result
- wdata_i  in  32  store data (rs2), right-aligned
- busy_o  out  1  stall request to the pipeline
- valid_o  out  1  one-cycle pulse: operation complete
- rdata_o  out  32  extended load data, valid while valid_o is high
- misaligned_o  out  1  one-cycle pulse: access rejected as misaligned
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_we_o  out  1  bus write enable
- data_be_o  out  4  byte enables
- data_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}
- data_wdata_o  out  32  lane-replicated store data
- data_rvalid_i  in  1  bus response, returned for both loads and stores
- data_rdata_i  in  32  bus read data

## Operation
- States: IDLE, REQ, WAIT.
- **IDLE**
  - On req_i high, check alignment. A halfword is misaligned when addr[0]=1. A word is misaligned when addr[1:0]≠0.
  - Misaligned: pulse misaligned_o for the next cycle, issue no bus request, stay in IDLE, leave valid_o low.
  - Aligned: latch we, size, unsigned, addr[1:0], word address, byte enables and lane data, then go to REQ.
- **REQ**
  - data_req_o is high. All data_* outputs stay stable until data_gnt_i is sampled high, then go to WAIT.
  - data_req_o drops in the cycle after the grant.
- **WAIT**
  - On data_rvalid_i high, go to IDLE and pulse valid_o for one cycle.
  - Loads: register rdata_o.
  - Stores: rdata_o holds its previous value.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - halfword: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store data lanes:
  - byte: {4{wdata[7:0]}}
  - halfword: {2{wdata[15:0]}}
  - word: wdata unchanged
- Load data: shift data_rdata_i right by 8·addr[1:0], take the low 8, 16 or 32 bits, then extend by unsigned_i (word loads are not extended).
- busy_o = (IDLE & req_i & aligned) | REQ | WAIT. It is combinational and low in the cycle valid_o is high.
- req_i is ignored outside IDLE. The pipeline must hold it stable under busy_o.
- data_rvalid_i is ignored in IDLE and REQ.

## Timing
- Reset values: every output is 0, state is IDLE, rdata_o = 0.
- Reset mid-transaction: data_req_o drops immediately (asynchronous). A late data_rvalid_i after reset is ignored.
- Minimum latency, req_i accepted to valid_o (grant in the first REQ cycle, rvalid in the cycle after the grant):
  - Cycle 0: req_i sampled.
  - Cycle 1: data_req_o high, data_gnt_i high.
  - Cycle 2: data_rvalid_i high.
  - Cycle 3: valid_o high.
- Grant wait cycles and response wait cycles each add one cycle per wait cycle.
- misaligned_o rises one cycle after req_i is sampled. Back-to-back accepts are allowed from the valid_o cycle onward.
- Only one transaction is outstanding at a time. data_rvalid_i in the same cycle as the grant is illegal bus behaviour.

## Test plan
- Word load, addr=0x1000, bus returns 0xDEADBEEF with 0 wait states: data_addr_o=0x1000, be=1111, valid_o at cycle 3, rdata_o=0xDEADBEEF.
- Signed byte load at addr=0x1003, rdata=0x80FFFFFF: be=1000, rdata_o=0xFFFFFF80. Repeat with unsigned_i=1: rdata_o=0x00000080.
- Halfword store at addr=0x2002, wdata=0x1234ABCD: data_we_o=1, be=1100, data_wdata_o=0xABCDABCD. Grant delayed 3 cycles: outputs stable throughout, busy_o high until valid_o.
- Misaligned word load at addr=0x3001 and misaligned halfword at 0x3003: misaligned_o pulses once each, data_req_o never rises, valid_o stays 0.
- rst_ni asserted in WAIT, then rvalid arrives after reset release: all outputs 0, no valid_o. A following word load at 0x4000 completes normally.
- Back-to-back: load then store, each with 2-cycle response wait: exactly two valid_o pulses, busy_o continuously high between accept and the final completion except in valid_o cycles.
